problem6: RTL and testbench



---
 rtl/problem6_pkg.sv | 13 +
 rtl/problem6_field_sel.sv | 37 +++
 rtl/problem6.sv | 42 ++++
 tb/tb_problem6.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/problem6_pkg.sv
// Shared widths and field layout for the problem6 packed-word field selector.
package problem6_pkg;

  localparam int SEL_W   = 2;
  localparam int FIELD_W = 3;
  localparam int DATA_W  = 16;

  // LSB position of field k within the packed input word.
  function automatic int field_base(input int sel_w, input int field_w, input int k);
    return sel_w + field_w * k;
  endfunction

endpackage

// File: rtl/problem6_field_sel.sv
// Combinational mux picking field[sel] out of the packed input word.
module problem6_field_sel
  import problem6_pkg::*;
#(
  parameter int P_SEL_W   = SEL_W,
  parameter int P_FIELD_W = FIELD_W,
  parameter int P_DATA_W  = DATA_W
) (
  input  logic [P_DATA_W-1:0]  i_data,
  output logic [P_FIELD_W-1:0] o_field
);

  localparam int N_FIELDS = 2 ** P_SEL_W;
  localparam int USED_W   = P_SEL_W + P_FIELD_W * N_FIELDS;

  logic [P_SEL_W-1:0] sel;

  assign sel = i_data[P_SEL_W-1:0];

  always_comb begin
    o_field = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      if (sel == P_SEL_W'(k)) begin
        o_field = i_data[field_base(P_SEL_W, P_FIELD_W, k) +: P_FIELD_W];
      end
    end
  end

  // Spare MSBs never reach the mux.
  generate
    if (P_DATA_W > USED_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^i_data[P_DATA_W-1:USED_W];
    end
  endgenerate

endmodule

// File: rtl/problem6.sv
// Field selector top: registers the selected field with a synchronous reset.
module problem6
  import problem6_pkg::*;
#(
  parameter int P_SEL_W   = SEL_W,
  parameter int P_FIELD_W = FIELD_W,
  parameter int P_DATA_W  = DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [P_DATA_W-1:0]  i_data,
  output logic [P_FIELD_W-1:0] o_data
);

  logic [P_FIELD_W-1:0] field;
  logic [P_FIELD_W-1:0] o_data_d;
  logic [P_FIELD_W-1:0] o_data_q;

  problem6_field_sel #(
    .P_SEL_W   (P_SEL_W),
    .P_FIELD_W (P_FIELD_W),
    .P_DATA_W  (P_DATA_W)
  ) u_field_sel (
    .i_data  (i_data),
    .o_field (field)
  );

  always_comb begin
    o_data_d = field;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_q <= '0;
    end else begin
      o_data_q <= o_data_d;
    end
  end

  assign o_data = o_data_q;

endmodule

// File: tb/tb_problem6.sv
// Self-checking bench for problem6: scoreboard of per-edge expected fields plus directed checks.
module tb_problem6;

  localparam logic [15:0] BASE = 16'b00_111_110_010_101_00;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_data;
  logic [2:0]  o_data;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;
  logic [2:0] exp_q[$];

  problem6 dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .o_data (o_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_field(input logic [15:0] w);
    case (w[1:0])
      2'b00:   return w[4:2];
      2'b01:   return w[7:5];
      2'b10:   return w[10:8];
      default: return w[13:11];
    endcase
  endfunction

  // Scoreboard: expectation pushed from inputs seen at the edge, popped once output settles.
  initial forever begin
    @(posedge i_clk);
    if (chk_en) begin
      exp_q.push_back(i_rst ? 3'b000 : model_field(i_data));
      #1;
      if (exp_q.size() == 0) chk("sb_empty", o_data, 3'bxxx);
      else chk("sb", o_data, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_sel [4];
    exp_sel = '{3'b101, 3'b010, 3'b110, 3'b111};

    i_rst  = 1'b1;
    i_data = BASE;
    @(negedge i_clk);
    chk_en = 1;

    repeat (2) begin
      @(negedge i_clk);
      chk("reset", o_data, 3'b000);
    end

    for (int s = 0; s < 4; s++) begin
      i_rst = 1'b0;
      i_data = BASE;
      i_data[1:0] = 2'(s);
      @(negedge i_clk);
      chk("sel_first", o_data, exp_sel[s]);
      @(negedge i_clk);
      chk("sel_hold", o_data, exp_sel[s]);
    end

    // Reset toggles every 1.5 periods while select steps every 3 periods.
    fork
      begin
        #2;
        repeat (8) begin
          i_rst = ~i_rst;
          #15;
        end
        i_rst = 1'b0;
      end
      begin
        for (int s = 0; s < 4; s++) begin
          i_data[1:0] = 2'(s);
          #30;
        end
      end
    join
    @(negedge i_clk);

    i_rst = 1'b0;
    i_data = BASE;
    i_data[1:0] = 2'b10;
    for (int sp = 0; sp < 4; sp++) begin
      i_data[15:14] = 2'(sp);
      @(negedge i_clk);
      chk("spare", o_data, 3'b110);
    end
    i_data[15:14] = 2'bxx;
    @(negedge i_clk);
    chk("spare_x", o_data, 3'b110);
    i_data[15:14] = 2'b00;
    @(negedge i_clk);

    i_data[10:8] = 3'b001;
    chk("f2_before", o_data, 3'b110);
    @(negedge i_clk);
    chk("f2_after", o_data, 3'b001);

    i_data = BASE;
    i_data[1:0] = 2'b11;
    @(negedge i_clk);
    chk("pulse_pre", o_data, 3'b111);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("pulse_rst", o_data, 3'b000);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("pulse_post", o_data, 3'b111);

    chk_en = 0;
    @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
